// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: frame state encoding and line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake bundle: one valid/ready pair and one data byte per requester.
interface uart_tx_sched_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first requester at or above ptr, searching upward with wrap.
module uart_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk from the far end back toward ptr so the closest candidate wins last.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[(int'(ptr) + j) % N_REQ]) begin
                any = 1'b1;
                idx = IDX_W'((int'(ptr) + j) % N_REQ);
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: accepts one byte per frame from N_REQ sources and
// serialises it as 8N1/8N2, stepping only on the external 1x baud strobe.
//
// state | meaning
// IDLE  | line high, arbitrating; a valid requester is accepted this cycle
// SYNC  | byte latched, line high, waiting for the first strobe after accept
// START | start bit (low) on the line
// DATA  | data bits on the line, LSB first
// STOP  | stop bit(s) on the line
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 8,
    parameter  int STOP_BITS = 1,
    localparam int GRANT_W   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stb_baud,
    uart_tx_sched_if.slave     req,
    output logic               serial_out,
    output logic               busy,
    output logic [GRANT_W-1:0] grant_id
);

    localparam int BIT_W = $clog2(DATA_W);

    tx_state_t          state, state_nxt;
    logic [DATA_W-1:0]  shift_q, shift_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic               stop_cnt, stop_cnt_nxt;
    logic               serial_nxt;
    logic               busy_nxt;
    logic [GRANT_W-1:0] grant_nxt;
    logic [GRANT_W-1:0] rr_ptr, rr_ptr_nxt;

    logic [N_REQ-1:0]   arb_gnt;
    logic [GRANT_W-1:0] arb_idx;
    logic               arb_any;

    uart_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req (req.req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Gated by rst_n as well, since the async reset forces IDLE while requesters may be valid.
    assign req.req_ready = (rst_n && state == IDLE) ? arb_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            serial_out <= UART_IDLE_LVL;
            busy       <= 1'b0;
            grant_id   <= '0;
            rr_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            serial_out <= serial_nxt;
            busy       <= busy_nxt;
            grant_id   <= grant_nxt;
            rr_ptr     <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        serial_nxt   = serial_out;
        busy_nxt     = busy;
        grant_nxt    = grant_id;
        rr_ptr_nxt   = rr_ptr;

        case (state)
            IDLE: begin
                if (arb_any) begin
                    shift_nxt  = req.req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    grant_nxt  = arb_idx;
                    rr_ptr_nxt = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + GRANT_W'(1);
                    busy_nxt   = 1'b1;
                    state_nxt  = SYNC;
                end
            end
            SYNC: begin
                if (stb_baud) begin
                    serial_nxt = 1'b0;
                    state_nxt  = START;
                end
            end
            START: begin
                if (stb_baud) begin
                    serial_nxt  = shift_q[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (stb_baud) begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        serial_nxt   = UART_IDLE_LVL;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = STOP;
                    end else begin
                        shift_nxt   = shift_q >> 1;
                        serial_nxt  = shift_q[1];
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (stb_baud) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                serial_nxt = UART_IDLE_LVL;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Schedules one UART transmit line among N_REQ byte sources.
- Arbitrates round-robin, accepts one byte per frame over a valid/ready handshake, and serialises it as 8N1/8N2.
- Bit timing comes from an external baud strobe (the 1x strobe of the baud generator). The block has no timing counter of its own.
- Sits between producer blocks (debug console, status reporter, etc.) and the UART TX pin.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- DATA_W, 8: data bits per frame, sent LSB first.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- GRANT_W, $clog2(N_REQ): width of grant_id; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- stb_baud  in  1  one-cycle pulse, once per bit period.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  N_REQ*DATA_W  requester i's byte in bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot accept; combinational.
- serial_out  out  1  UART TX line; idle high.
- busy  out  1  high from the accept cycle until the frame ends.
- grant_id  out  GRANT_W  index of the last accepted requester; registered.

Behaviour:
- Reset is asynchronous and active-low; one clock domain (clk).
- Reset values:
  - state IDLE, serial_out=1, busy=0, grant_id=0, rr pointer=0, bit counters=0.
  - req_ready is forced to all-zero while rst_n=0.
- States: IDLE -> SYNC -> START -> DATA -> STOP -> IDLE.
- Arbitration (IDLE only):
  - Search starts at the rr pointer and picks the first i with req_valid[i]=1, searching upward with wrap.
  - req_ready[i]=1 for that i only. All-zero when no requester is valid or state != IDLE.
- Handshake:
  - A transfer happens in the cycle where req_valid[i]&&req_ready[i] (accept cycle T).
  - Requesters hold valid and data stable until accepted; the block does not check this.
  - At T+1:
    - shift register = req_data[i].
    - grant_id = i.
    - rr pointer = (i+1) mod N_REQ.
    - busy = 1.
    - state = SYNC.
- SYNC:
  - serial_out stays 1.
  - A stb_baud in cycle T is ignored.
  - On the first stb_baud strictly after T: serial_out<=0, state START. This aligns the start bit to the baud grid.
- START: on the next stb_baud, serial_out<=shift[0], bit_cnt<=0, state DATA.
- DATA:
  - On each stb_baud: if bit_cnt==DATA_W-1 then serial_out<=1, stop_cnt<=0, state STOP. Otherwise shift right, serial_out<=next bit, bit_cnt++.
  - Every bit is held for exactly one strobe interval.
- STOP:
  - On each stb_baud: if stop_cnt==STOP_BITS-1 then state IDLE, busy<=0. Otherwise stop_cnt++.
  - serial_out stays 1 throughout.
- Back-to-back frames:
  - A new accept can happen in the first IDLE cycle.
  - The line stays high through SYNC, so the stop-bit length is never shortened.
- Strobe behaviour:
  - stb_baud is ignored in IDLE.
  - Every state change outside IDLE/SYNC happens only on stb_baud.
- Starvation-free: a requester that stays valid is granted within N_REQ frames.
- Reset mid-frame:
  - serial_out goes high immediately (asynchronous); the partial frame is dropped and not retried.
  - The requester whose byte was already accepted is not re-signalled.
- Counter widths: bit_cnt is $clog2(DATA_W) bits; stop_cnt is 1 bit. No wrap beyond the terminal values.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, SYNC, START, DATA, STOP}.
  - localparam UART_IDLE_LVL = 1'b1.
- One sub-module: uart_rr_arb.
  - Inputs: req vector, pointer. Outputs: one-hot grant, index, any.
  - Combinational; the pointer register lives in uart_tx_sched.
- Rest is a single always_ff FSM/datapath plus combinational ready.

Test Plan:
1. Reset and idle: rst_n low for 3 cycles with all valids high. Require req_ready=0, serial_out=1, busy=0, grant_id=0. After release, req_ready=4'b0001 in the first cycle.
2. Single frame: stb_baud every 4 cycles; requester 2 sends 8'hA5, STOP_BITS=1. Require:
   - Line sequence, one bit per strobe: 0,1,0,1,0,0,1,0,1,1.
   - grant_id=2; busy falls on the stop-bit-ending strobe.
3. Round-robin fairness: all four valid continuously, bytes 8'h10..8'h13. Require grants in order 0,1,2,3,0 and exactly one req_ready bit per accept.
4. Strobe coincident with accept: stb_baud high in accept cycle T. Require serial_out high at T+1 and the start bit beginning only at the next strobe.
5. Two stop bits: STOP_BITS=2, two back-to-back frames 8'hFF then 8'h00. Require at least 2 high bit periods between the last data bit and the next start bit.
6. Reset mid-frame: assert rst_n during DATA bit 3. Require serial_out=1 and busy=0 asynchronously, with no further low bits after release.
